// File: rtl/systolic_feeder_if.sv
// Bundle between the 2x2 systolic feeder, its host and the attached array:
// job operands, skewed streams, accumulator read-back and result handshake.
interface systolic_feeder_if #(
  parameter int DW = 8,
  parameter int CW = 18
);
  logic                 start;
  logic signed [DW-1:0] a11, a12, a21, a22;
  logic signed [DW-1:0] b11, b12, b21, b22;
  logic                 busy;
  logic                 arr_clr;
  logic signed [DW-1:0] a1, a2, b1, b2;
  logic signed [CW-1:0] c11, c12, c21, c22;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [CW-1:0] r11, r12, r21, r22;

  // Host plus array side: drives jobs, accumulator values and ready.
  modport master (
    output start, a11, a12, a21, a22, b11, b12, b21, b22,
    output c11, c12, c21, c22, res_ready,
    input  busy, arr_clr, a1, a2, b1, b2, res_valid, r11, r12, r21, r22
  );

  modport slave (
    input  start, a11, a12, a21, a22, b11, b12, b21, b22,
    input  c11, c12, c21, c22, res_ready,
    output busy, arr_clr, a1, a2, b1, b2, res_valid, r11, r12, r21, r22
  );
endinterface

// File: rtl/systolic_feeder.sv
// Sequences one 2x2 matrix job into a systolic array: clear, three skewed
// feed cycles, a zero-input drain, result capture and a valid/ready hold.
module systolic_feeder #(
  parameter int DW    = 8,
  parameter int CW    = 18,
  parameter int DRAIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED0, S_FEED1, S_FEED2, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic capture;

  logic signed [DW-1:0] la11, la12, la21, la22;
  logic signed [DW-1:0] lb11, lb12, lb21, lb22;

  logic signed [DW-1:0] a1_nx, a2_nx, b1_nx, b2_nx;
  logic signed [DW-1:0] a1_q, a2_q, b1_q, b2_q;
  logic signed [CW-1:0] r11_q, r12_q, r21_q, r22_q;
  logic busy_q, clr_q, valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The drain counter walks DRAIN zero-input cycles down to zero; the cycle
  // spent at zero is the capture cycle that samples the settled accumulators.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_FEED0;
      S_FEED0: state_nx = S_FEED1;
      S_FEED1: state_nx = S_FEED2;
      S_FEED2: begin
        state_nx = S_DRAIN;
        cnt_nx   = 4'(DRAIN);
      end
      S_DRAIN: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_DONE:  if (bus.res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stream values are chosen from the upcoming state so they appear,
  // registered, in the same cycle the FSM occupies that state.
  always_comb begin
    a1_nx = '0;
    a2_nx = '0;
    b1_nx = '0;
    b2_nx = '0;
    case (state_nx)
      S_FEED0: begin
        a1_nx = la11;
        b1_nx = lb11;
      end
      S_FEED1: begin
        a1_nx = la12;
        b1_nx = lb21;
        a2_nx = la21;
        b2_nx = lb12;
      end
      S_FEED2: begin
        a2_nx = la22;
        b2_nx = lb22;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      la11 <= '0; la12 <= '0; la21 <= '0; la22 <= '0;
      lb11 <= '0; lb12 <= '0; lb21 <= '0; lb22 <= '0;
    end else if (state == S_IDLE && bus.start) begin
      la11 <= bus.a11; la12 <= bus.a12; la21 <= bus.a21; la22 <= bus.a22;
      lb11 <= bus.b11; lb12 <= bus.b12; lb21 <= bus.b21; lb22 <= bus.b22;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      r11_q   <= '0;
      r12_q   <= '0;
      r21_q   <= '0;
      r22_q   <= '0;
    end else begin
      busy_q  <= (state_nx != S_IDLE);
      clr_q   <= (state_nx == S_CLEAR);
      valid_q <= (state_nx == S_DONE);
      a1_q    <= a1_nx;
      a2_q    <= a2_nx;
      b1_q    <= b1_nx;
      b2_q    <= b2_nx;
      if (capture) begin
        r11_q <= bus.c11;
        r12_q <= bus.c12;
        r21_q <= bus.c21;
        r22_q <= bus.c22;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.arr_clr   = clr_q;
  assign bus.res_valid = valid_q;
  assign bus.a1        = a1_q;
  assign bus.a2        = a2_q;
  assign bus.b1        = b1_q;
  assign bus.b2        = b2_q;
  assign bus.r11       = r11_q;
  assign bus.r12       = r12_q;
  assign bus.r21       = r21_q;
  assign bus.r22       = r22_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with a behavioural 2x2 systolic array attached;
// expectations come from plain matrix arithmetic and the skew rule.
module tb_systolic_feeder;
  localparam int DW    = 8;
  localparam int CW    = 18;
  localparam int DRAIN = 4;
  localparam int LAT   = 5 + DRAIN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DW(DW), .CW(CW)) bus();

  systolic_feeder #(.DW(DW), .CW(CW), .DRAIN(DRAIN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int ma[2][2];
  int mb[2][2];
  logic signed [CW-1:0] er[2][2];

  // Output-stationary 2x2 array: a flows right, b flows down, one register per hop.
  logic signed [DW-1:0] p11a, p11b, p12b, p21a;
  logic signed [CW-1:0] acc11, acc12, acc21, acc22;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.arr_clr) begin
      p11a <= '0; p11b <= '0; p12b <= '0; p21a <= '0;
      acc11 <= '0; acc12 <= '0; acc21 <= '0; acc22 <= '0;
    end else begin
      acc11 <= acc11 + CW'(bus.a1) * CW'(bus.b1);
      acc12 <= acc12 + CW'(p11a) * CW'(bus.b2);
      acc21 <= acc21 + CW'(bus.a2) * CW'(p11b);
      acc22 <= acc22 + CW'(p21a) * CW'(p12b);
      p11a <= bus.a1;
      p11b <= bus.b1;
      p12b <= bus.b2;
      p21a <= bus.a2;
    end
  end
  assign bus.c11 = acc11;
  assign bus.c12 = acc12;
  assign bus.c21 = acc21;
  assign bus.c22 = acc22;

  // Skew rule: at feed step t, row i carries A[i][t-i] and column j carries B[t-j][j].
  function automatic int row_op(int i, int t);
    int idx = t - i;
    if (idx < 0 || idx > 1) return 0;
    return ma[i][idx];
  endfunction

  function automatic int col_op(int j, int t);
    int idx = t - j;
    if (idx < 0 || idx > 1) return 0;
    return mb[idx][j];
  endfunction

  function automatic int mm(int i, int j);
    return ma[i][0] * mb[0][j] + ma[i][1] * mb[1][j];
  endfunction

  task automatic drive_ops();
    bus.a11 = DW'(ma[0][0]); bus.a12 = DW'(ma[0][1]);
    bus.a21 = DW'(ma[1][0]); bus.a22 = DW'(ma[1][1]);
    bus.b11 = DW'(mb[0][0]); bus.b12 = DW'(mb[0][1]);
    bus.b21 = DW'(mb[1][0]); bus.b22 = DW'(mb[1][1]);
  endtask

  task automatic drive_junk_ops();
    bus.a11 = DW'($urandom); bus.a12 = DW'($urandom);
    bus.a21 = DW'($urandom); bus.a22 = DW'($urandom);
    bus.b11 = DW'($urandom); bus.b12 = DW'($urandom);
    bus.b21 = DW'($urandom); bus.b22 = DW'($urandom);
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = int'($urandom_range(255)) - 128;
        mb[i][j] = int'($urandom_range(255)) - 128;
      end
  endtask

  // Entered at a falling edge; runs one job to DONE, optionally pulsing start
  // mid-job, and optionally completing the handshake.
  task automatic test_job(input string name, input bit poke, input bit handshake);
    logic [4*DW-1:0] exp_s;
    logic [4*CW-1:0] hold_r, new_r, got_r;
    hold_r = {er[0][0], er[0][1], er[1][0], er[1][1]};
    new_r  = {CW'(mm(0, 0)), CW'(mm(0, 1)), CW'(mm(1, 0)), CW'(mm(1, 1))};
    drive_ops();
    bus.start = 1'b1;
    bus.res_ready = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      exp_s = {DW'(row_op(0, k - 1)), DW'(row_op(1, k - 1)),
               DW'(col_op(0, k - 1)), DW'(col_op(1, k - 1))};
      checks++;
      if ({bus.a1, bus.a2, bus.b1, bus.b2} !== exp_s) begin
        errors++;
        $display("[TB] FAIL %s streams k=%0d: got %h expected %h", name, k,
                 {bus.a1, bus.a2, bus.b1, bus.b2}, exp_s);
      end
      checks++;
      if ({bus.busy, bus.arr_clr, bus.res_valid} !== {1'b1, k == 0, k == LAT}) begin
        errors++;
        $display("[TB] FAIL %s busy/clr/valid k=%0d: got %b expected %b", name, k,
                 {bus.busy, bus.arr_clr, bus.res_valid}, {1'b1, k == 0, k == LAT});
      end
      got_r = {bus.r11, bus.r12, bus.r21, bus.r22};
      checks++;
      if (got_r !== (k == LAT ? new_r : hold_r)) begin
        errors++;
        $display("[TB] FAIL %s result k=%0d: got %h expected %h", name, k, got_r,
                 (k == LAT ? new_r : hold_r));
      end
      bus.start = poke && (k == 2 || k == LAT - 3);
      if (poke) drive_junk_ops();
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        er[i][j] = CW'(mm(i, j));
    if (handshake) begin
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      checks++;
      if ({bus.busy, bus.res_valid, bus.arr_clr} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL %s after handshake: got %b expected 000", name,
                 {bus.busy, bus.res_valid, bus.arr_clr});
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.arr_clr, bus.res_valid, bus.a1, bus.a2, bus.b1, bus.b2,
         bus.r11, bus.r12, bus.r21, bus.r22} !== '0) begin
      errors++;
      $display("[TB] FAIL reset outputs: got nonzero %h expected 0",
               {bus.busy, bus.arr_clr, bus.res_valid, bus.a1, bus.a2, bus.b1, bus.b2});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle after reset: busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    ma = '{'{1, 2}, '{3, 4}};
    mb = '{'{5, 6}, '{7, 8}};
    test_job("basic", 1'b0, 1'b1);
  endtask

  task automatic test_signed();
    ma = '{'{-1, 2}, '{3, -4}};
    mb = '{'{5, -6}, '{7, 8}};
    test_job("signed", 1'b0, 1'b1);
  endtask

  task automatic test_random();
    repeat (4) begin
      randomize_mats();
      test_job("random", 1'b0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    randomize_mats();
    test_job("backpressure", 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.busy, bus.r11, bus.r12, bus.r21, bus.r22} !==
          {2'b11, er[0][0], er[0][1], er[1][0], er[1][1]}) begin
        errors++;
        $display("[TB] FAIL backpressure hold: got valid=%b r=%h expected valid=1 r=%h",
                 bus.res_valid, {bus.r11, bus.r12, bus.r21, bus.r22},
                 {er[0][0], er[0][1], er[1][0], er[1][1]});
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.busy, bus.res_valid, bus.r11, bus.r12, bus.r21, bus.r22} !==
        {2'b00, er[0][0], er[0][1], er[1][0], er[1][1]}) begin
      errors++;
      $display("[TB] FAIL backpressure release: got busy=%b valid=%b expected 0 0 with r retained",
               bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_back_to_back();
    randomize_mats();
    test_job("b2b_first", 1'b0, 1'b0);
    randomize_mats();
    drive_ops();
    bus.start = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.busy, bus.res_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b2b start at handshake: got busy/valid %b expected 00",
               {bus.busy, bus.res_valid});
    end
    test_job("b2b_second", 1'b0, 1'b1);
  endtask

  task automatic test_start_while_busy();
    randomize_mats();
    test_job("start_busy", 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    randomize_mats();
    drive_ops();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.a2 !== DW'(ma[1][0])) begin
      errors++;
      $display("[TB] FAIL async pre-reset FEED1 a2: got %h expected %h", bus.a2, DW'(ma[1][0]));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.arr_clr, bus.res_valid, bus.a1, bus.a2, bus.b1, bus.b2,
         bus.r11, bus.r12, bus.r21, bus.r22} !== '0) begin
      errors++;
      $display("[TB] FAIL async reset outputs: got nonzero %h expected 0",
               {bus.busy, bus.arr_clr, bus.res_valid, bus.a1, bus.a2, bus.b1, bus.b2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        er[i][j] = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.res_valid} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL abandoned job k=%0d: got busy/valid %b expected 00", k,
                 {bus.busy, bus.res_valid});
      end
    end
    randomize_mats();
    test_job("after_reset", 1'b0, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    ma = '{'{0, 0}, '{0, 0}};
    mb = '{'{0, 0}, '{0, 0}};
    drive_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        er[i][j] = '0;
    test_reset();
    test_basic();
    test_signed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_start_while_busy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
